// File: rtl/uart2wb_burst.sv
// uart2wb_burst: UART host bridge to a pipelined Wishbone master.
// Byte commands drive single/burst accesses and return one status byte.

module uart_core #(
  parameter int unsigned DIV = 867
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txen,
  input  logic       rxen,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid
);
  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic          tx_busy_q, tx_busy_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          rx_s1_q, rx_s2_q;
  logic          rx_busy_q, rx_busy_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;

  assign tx_ready = txen & ~tx_busy_q;
  assign txd      = tx_sh_q[0];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_sh_d   = tx_sh_q;
    tx_bit_d  = tx_bit_q;
    tx_cnt_d  = tx_cnt_q;
    if (!tx_busy_q) begin
      if (tx_valid && tx_ready) begin
        tx_busy_d = 1'b1;
        tx_sh_d   = {1'b1, tx_data, 1'b0};
        tx_bit_d  = '0;
        tx_cnt_d  = '0;
      end
    end else if (tx_cnt_q == FULL) begin
      tx_cnt_d = '0;
      tx_sh_d  = {1'b1, tx_sh_q[9:1]};
      if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
      else tx_bit_d = tx_bit_q + 4'd1;
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  // Start bit is re-checked at half a bit, later bits sampled mid-cell
  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_cnt_d   = rx_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (!rx_busy_q) begin
      if (rxen && !rx_s2_q) begin
        rx_busy_d = 1'b1;
        rx_bit_d  = '0;
        rx_cnt_d  = '0;
      end
    end else if (rx_cnt_q == ((rx_bit_q == 4'd0) ? HALF : FULL)) begin
      rx_cnt_d = '0;
      rx_bit_d = rx_bit_q + 4'd1;
      if (rx_bit_q == 4'd0) begin
        if (rx_s2_q) rx_busy_d = 1'b0;
      end else if (rx_bit_q == 4'd9) begin
        rx_busy_d  = 1'b0;
        rx_valid_d = rx_s2_q;
        rx_data_d  = rx_sh_q;
      end else begin
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
      end
    end else begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_sh_q    <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_busy_q  <= rx_busy_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end
endmodule

module uart2wb_burst #(
  parameter int ADDR_BYTE = 2,
  parameter int DATA_BYTE = 2,
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 100,
  parameter int ADDR_INC  = 1,
  parameter int TIMEOUT   = 255,
  parameter int AW        = 8 * ADDR_BYTE,
  parameter int DW        = 8 * DATA_BYTE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          uart_txd,
  input  logic          uart_rxd,
  output logic          rst_n_out,
  output logic          busy,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_stall_i
);
  localparam int DIV = CLK_FREQ * 1000000 / BAUD_RATE - 1;
  localparam int TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA,
    S_ACCESS, S_WAIT, S_SEND, S_STATUS
  } state_t;

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic          burst_q, burst_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    words_q, words_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          rst_out_q, rst_out_d;
  logic          tx_ready, rx_valid;
  logic [7:0]    rx_data;

  uart_core #(.DIV(DIV)) u_uart (
    .clk      (clk),
    .rst_n    (rst_n),
    .txen     (enable),
    .rxen     (enable),
    .tx_data  (tx_data_q),
    .tx_valid (tx_valid_q),
    .tx_ready (tx_ready),
    .txd      (uart_txd),
    .rxd      (uart_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  assign rst_n_out = rst_out_q;
  assign busy      = (state_q != S_IDLE);
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rst_out_d  = rst_out_q;
    unique case (state_q)
      S_IDLE: if (rx_valid) begin
        cnt_d   = '0;
        words_d = '0;
        err_d   = 1'b0;
        case (rx_data)
          8'h01: begin wr_d = 1'b0; burst_d = 1'b0; state_d = S_ADDR; end
          8'h02: begin wr_d = 1'b1; burst_d = 1'b0; state_d = S_ADDR; end
          8'h03: begin wr_d = 1'b0; burst_d = 1'b1; state_d = S_ADDR; end
          8'h04: begin wr_d = 1'b1; burst_d = 1'b1; state_d = S_ADDR; end
          8'hFE: rst_out_d = 1'b0;
          8'hFF: rst_out_d = 1'b1;
          default: ;
        endcase
      end
      S_ADDR: if (rx_valid) begin
        adr_d = (adr_q >> 8) | (AW'(rx_data) << (AW - 8));
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(ADDR_BYTE - 1)) begin
          cnt_d   = '0;
          state_d = burst_q ? S_LEN : (wr_q ? S_DATA : S_ACCESS);
        end
      end
      S_LEN: if (rx_valid) begin
        words_d = rx_data;
        state_d = wr_q ? S_DATA : S_ACCESS;
      end
      S_DATA: if (rx_valid) begin
        dat_d = (dat_q >> 8) | (DW'(rx_data) << (DW - 8));
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(DATA_BYTE - 1)) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS, S_WAIT: begin
        if (state_q == S_ACCESS && !wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
        // A zero-wait slave may answer in the cycle the strobe is taken
        if ((state_q == S_WAIT || !wb_stall_i) && (wb_ack_i || wb_err_i)) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          if (wb_err_i) begin
            err_d   = 1'b1;
            state_d = S_STATUS;
          end else begin
            adr_d = adr_q + AW'(ADDR_INC);
            if (!wr_q) begin
              dat_d   = wb_dat_i;
              state_d = S_SEND;
            end else if (words_q != 8'd0) begin
              words_d = words_q - 8'd1;
              state_d = S_DATA;
            end else begin
              state_d = S_STATUS;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_STATUS;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SEND: if (tx_valid_q && tx_ready) begin
        dat_d     = dat_q >> 8;
        tx_data_d = dat_d[7:0];
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == 8'(DATA_BYTE - 1)) begin
          tx_valid_d = 1'b0;
          if (words_q != 8'd0) begin
            words_d = words_q - 8'd1;
            state_d = S_ACCESS;
          end else begin
            state_d = S_STATUS;
          end
        end
      end
      S_STATUS: if (tx_valid_q && tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ACCESS && state_q != S_ACCESS) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d  = wr_q;
      tmo_d = '0;
    end
    if (state_d == S_SEND && state_q != S_SEND) begin
      tx_data_d  = dat_d[7:0];
      tx_valid_d = 1'b1;
      cnt_d      = '0;
    end
    if (state_d == S_STATUS && state_q != S_STATUS) begin
      tx_data_d  = err_d ? 8'hEE : 8'hA5;
      tx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      burst_q    <= 1'b0;
      cnt_q      <= '0;
      words_q    <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rst_out_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rst_out_q  <= rst_out_d;
    end
  end
endmodule
